// File: rtl/instr_pkg.sv
// Shared instruction-set definitions: mnemonic codes, opcode/func constants, field packers
// and encoder FSM states. Build macro ENC_CHECK_EN (used by instr_encoder) rejects undefined mnemonics.
package instr_pkg;

    typedef enum logic [4:0] {
        MnLw, MnSw, MnAddi, MnAddiu, MnSlti, MnSltiu, MnOri, MnLui, MnAndi, MnXori,
        MnBeq, MnBne, MnJ, MnJal,
        MnAdd, MnAddu, MnSub, MnAnd, MnOr, MnXor, MnNor, MnSlt, MnSltu,
        MnSll, MnSllv, MnSrl, MnSrlv, MnSra, MnSrav, MnJr, MnJalr
    } mnem_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAddiu = 6'h09;
    localparam logic [5:0] OpSlti  = 6'h0a;
    localparam logic [5:0] OpSltiu = 6'h0b;
    localparam logic [5:0] OpAndi  = 6'h0c;
    localparam logic [5:0] OpOri   = 6'h0d;
    localparam logic [5:0] OpXori  = 6'h0e;
    localparam logic [5:0] OpLui   = 6'h0f;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2b;

    localparam logic [5:0] FnSll  = 6'h00;
    localparam logic [5:0] FnSrl  = 6'h02;
    localparam logic [5:0] FnSra  = 6'h03;
    localparam logic [5:0] FnSllv = 6'h04;
    localparam logic [5:0] FnSrlv = 6'h06;
    localparam logic [5:0] FnSrav = 6'h07;
    localparam logic [5:0] FnJr   = 6'h08;
    localparam logic [5:0] FnJalr = 6'h09;
    localparam logic [5:0] FnAdd  = 6'h20;
    localparam logic [5:0] FnAddu = 6'h21;
    localparam logic [5:0] FnSub  = 6'h22;
    localparam logic [5:0] FnAnd  = 6'h24;
    localparam logic [5:0] FnOr   = 6'h25;
    localparam logic [5:0] FnXor  = 6'h26;
    localparam logic [5:0] FnNor  = 6'h27;
    localparam logic [5:0] FnSlt  = 6'h2a;
    localparam logic [5:0] FnSltu = 6'h2b;

    typedef enum logic [1:0] {StIdle, StWrite, StFull} enc_state_e;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sh,
                                           input logic [5:0] fn);
        return {OpRtype, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] target);
        return {op, target};
    endfunction

endpackage

// File: rtl/instr_encode_comb.sv
// Pure combinational mnemonic-to-word mapping; known=0 flags a code with no defined encoding.
module instr_encode_comb
    import instr_pkg::*;
(
    input  logic [4:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        known
);

    always_comb begin
        word  = 32'h0000_0000;
        known = 1'b1;
        case (mnem)
            MnLw:    word = i_word(OpLw, rs, rt, imm);
            MnSw:    word = i_word(OpSw, rs, rt, imm);
            MnAddi:  word = i_word(OpAddi, rs, rt, imm);
            MnAddiu: word = i_word(OpAddiu, rs, rt, imm);
            MnSlti:  word = i_word(OpSlti, rs, rt, imm);
            MnSltiu: word = i_word(OpSltiu, rs, rt, imm);
            MnOri:   word = i_word(OpOri, rs, rt, imm);
            MnLui:   word = i_word(OpLui, 5'd0, rt, imm);
            MnAndi:  word = i_word(OpAndi, rs, rt, imm);
            MnXori:  word = i_word(OpXori, rs, rt, imm);
            MnBeq:   word = i_word(OpBeq, rs, rt, imm);
            MnBne:   word = i_word(OpBne, rs, rt, imm);
            MnJ:     word = j_word(OpJ, target);
            MnJal:   word = j_word(OpJal, target);
            MnAdd:   word = r_word(rs, rt, rd, 5'd0, FnAdd);
            MnAddu:  word = r_word(rs, rt, rd, 5'd0, FnAddu);
            MnSub:   word = r_word(rs, rt, rd, 5'd0, FnSub);
            MnAnd:   word = r_word(rs, rt, rd, 5'd0, FnAnd);
            MnOr:    word = r_word(rs, rt, rd, 5'd0, FnOr);
            MnXor:   word = r_word(rs, rt, rd, 5'd0, FnXor);
            MnNor:   word = r_word(rs, rt, rd, 5'd0, FnNor);
            MnSlt:   word = r_word(rs, rt, rd, 5'd0, FnSlt);
            MnSltu:  word = r_word(rs, rt, rd, 5'd0, FnSltu);
            // Immediate shifts take their amount from shamt, so rs is zeroed.
            MnSll:   word = r_word(5'd0, rt, rd, shamt, FnSll);
            MnSrl:   word = r_word(5'd0, rt, rd, shamt, FnSrl);
            MnSra:   word = r_word(5'd0, rt, rd, shamt, FnSra);
            MnSllv:  word = r_word(rs, rt, rd, 5'd0, FnSllv);
            MnSrlv:  word = r_word(rs, rt, rd, 5'd0, FnSrlv);
            MnSrav:  word = r_word(rs, rt, rd, 5'd0, FnSrav);
            MnJr:    word = r_word(rs, 5'd0, 5'd0, 5'd0, FnJr);
            MnJalr:  word = r_word(rs, 5'd0, rd, 5'd0, FnJalr);
            default: begin
                word  = 32'h0000_0000;
                known = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes one instruction request at a time and writes it to sequential imem addresses.
// Define ENC_CHECK_EN to reject undefined mnemonics (sticky err) instead of writing a nop.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int unsigned AW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    mnem,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    input  logic [4:0]    rd,
    input  logic [4:0]    shamt,
    input  logic [15:0]   imm,
    input  logic [25:0]   target,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wd,
    output logic          full,
    output logic [AW:0]   count,
    output logic          err
);

    enc_state_e    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   word_q, word_d;
    logic          err_q, err_d;
    logic [31:0]   enc_word;
    logic          enc_known;

    instr_encode_comb u_encode (
        .mnem   (mnem),
        .rs     (rs),
        .rt     (rt),
        .rd     (rd),
        .shamt  (shamt),
        .imm    (imm),
        .target (target),
        .word   (enc_word),
        .known  (enc_known)
    );

`ifndef ENC_CHECK_EN
    logic unused_known;
    assign unused_known = enc_known;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        word_d  = word_q;
        err_d   = err_q;
        imem_we = 1'b0;
        if (start) begin
            state_d = StIdle;
            addr_d  = '0;
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
`ifdef ENC_CHECK_EN
                        if (!enc_known) begin
                            err_d = 1'b1;
                        end else begin
                            word_d  = enc_word;
                            state_d = StWrite;
                        end
`else
                        word_d  = enc_word;
                        state_d = StWrite;
`endif
                    end
                end
                StWrite: begin
                    imem_we = 1'b1;
                    count_d = count_q + 1'b1;
                    // Last slot parks the address rather than wrapping back to 0.
                    if (addr_q == {AW{1'b1}}) begin
                        state_d = StFull;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = StIdle;
                    end
                end
                StFull: state_d = StFull;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            count_q <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            word_q  <= word_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == StIdle) && !start;
    assign full      = (state_q == StFull);
    assign count     = count_q;
    assign err       = err_q;
    assign imem_addr = addr_q;
    assign imem_wd   = word_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder at AW=2; expected writes are queued on accept and
// popped when the strobe appears.
module tb_instr_encoder;
    import instr_pkg::*;

    localparam int unsigned AW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [4:0]    mnem = 5'd0;
    logic [4:0]    rs = 5'd0;
    logic [4:0]    rt = 5'd0;
    logic [4:0]    rd = 5'd0;
    logic [4:0]    shamt = 5'd0;
    logic [15:0]   imm = 16'd0;
    logic [25:0]   target = 26'd0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wd;
    logic          full;
    logic [AW:0]   count;
    logic          err;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_addr = 0;

    instr_encoder #(.AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mnem      (mnem),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .shamt     (shamt),
        .imm       (imm),
        .target    (target),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wd   (imem_wd),
        .full      (full),
        .count     (count),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_we", 32'(imem_addr), 32'hffff_ffff);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("imem_addr", 32'(imem_addr), e.addr);
                check("imem_wd", imem_wd, e.wd);
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [4:0] m, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [4:0] sh, input logic [15:0] im,
                        input logic [25:0] tg, input logic [31:0] exp_wd, input bit exp_we);
        int n;
        mnem = m; rs = s; rt = t; rd = d; shamt = sh; imm = im; target = tg;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        if (exp_we) sb.push_back('{addr: 32'(exp_addr), wd: exp_wd});
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("we_latency", 32'(imem_we), 32'(exp_we));
        if (exp_we) exp_addr++;
    endtask

    initial begin
        @(negedge clk);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd1);

        // Fill all four slots back to back.
        send(MnAddi, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 26'd0, 32'h2008_0005, 1'b1);
        send(MnAdd, 5'd8, 5'd9, 5'd10, 5'd0, 16'd0, 26'd0, 32'h0109_5020, 1'b1);
        send(MnSll, 5'd7, 5'd9, 5'd8, 5'd2, 16'd0, 26'd0, 32'h0009_4080, 1'b1);
        send(MnJ, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h010_0000, 32'h0810_0000, 1'b1);
        @(negedge clk);
        check("full_set", 32'(full), 32'd1);
        check("full_count", 32'(count), 32'd4);

        // A held request must not be taken while full.
        mnem = MnAdd; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("full_ready", 32'(in_ready), 32'd0);
        end
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("start_full", 32'(full), 32'd0);
        check("start_count", 32'(count), 32'd0);
        exp_addr = 0;

        send(MnLw, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0010, 26'd0, 32'h8fa8_0010, 1'b1);
        send(MnJr, 5'd31, 5'd5, 5'd6, 5'd3, 16'd0, 26'd0, 32'h03e0_0008, 1'b1);
        send(MnJalr, 5'd4, 5'd7, 5'd31, 5'd1, 16'd0, 26'd0, 32'h0080_f809, 1'b1);
        send(MnLui, 5'd3, 5'd2, 5'd0, 5'd0, 16'h1234, 26'd0, 32'h3c02_1234, 1'b1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        exp_addr = 0;
        @(negedge clk);

        // Reset in the middle of a WRITE must kill the strobe.
        mnem = MnSub; rs = 5'd1; rt = 5'd2; rd = 5'd3; shamt = 5'd4;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("write_we", 32'(imem_we), 32'd1);
        #2 reset = 1'b1;
        #1 check("rst_mid_we", 32'(imem_we), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_count", 32'(count), 32'd0);
        check("rst_mid_ready", 32'(in_ready), 32'd1);
        send(MnBeq, 5'd1, 5'd2, 5'd0, 5'd0, 16'hffff, 26'd0, 32'h1022_ffff, 1'b1);

`ifdef ENC_CHECK_EN
        send(5'd31, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1111, 26'd0, 32'h0000_0000, 1'b0);
        check("undef_err", 32'(err), 32'd1);
`else
        send(5'd31, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1111, 26'd0, 32'h0000_0000, 1'b1);
        check("undef_err", 32'(err), 32'd0);
`endif
        send(MnSrav, 5'd5, 5'd6, 5'd7, 5'd9, 16'd0, 26'd0, 32'h00a6_3807, 1'b1);
        @(negedge clk);
        check("final_count", 32'(count), 32'(exp_addr));
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("start_err", 32'(err), 32'd0);
        check("start_count2", 32'(count), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
